// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the pipelined ALU: opcode encodings,
//               status-flag bit positions and handshake FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcodes 0-7 keep the legacy 8-bit ALU encoding.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    // Bit positions inside the flags bus {N,V,C,Z}.
    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_V = 2;
    localparam int F_N = 3;

    // Handshake FSM: IDLE accepts work, MUL waits on the iterative
    // multiplier, FIN holds a finished product until the output slot frees.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Unsigned shift-add multiplier, one multiplier bit per cycle.
//               A start pulse while idle loads the operands; WIDTH cycles
//               later product holds a*b and stays there until the next start.
// Ports       : clk, rst_n (sync, active low)
//               start   - load a/b and begin (ignored while busy)
//               a, b    - multiplicand / multiplier
//               busy    - iterations in progress
//               done    - high during the final iteration; product is
//                         complete after the coming clock edge
//               product - 2*WIDTH-bit accumulator
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start && !r_busy) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            // Add the shifted multiplicand for each set multiplier bit,
            // consuming the multiplier LSB-first.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    // Flagged one cycle early so the controlling FSM can advance on the
    // same edge that retires the last partial product.
    assign done    = r_busy && (r_cnt == c_last);
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Parametrised ALU with registered output, valid/ready
//               handshakes, {N,V,C,Z} status flags, shifts and an iterative
//               double-width multiply.
// Ports       : clk, rst_n (sync, active low)
//               in_valid/in_ready   - operation handshake (a, b, opcode)
//               out_valid/out_ready - result handshake
//               result, result_hi   - result (MUL: low / high product halves)
//               flags               - {N,V,C,Z}
//               err                 - reserved opcode issued
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int c_msb = WIDTH - 1;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic [3:0]         r_flags;
    logic               r_err;

    logic               w_slot_free;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_load_single;
    logic               w_load_mul;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_flags;

    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [3:0]         w_mul_flags;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_slot_free   = !r_out_valid || out_ready;
    assign in_ready      = (r_state == IDLE) && w_slot_free;
    assign w_accept      = in_valid && in_ready;
    assign w_mul_start   = w_accept && (opcode == OP_MUL);
    assign w_load_single = w_accept && (opcode != OP_MUL);
    assign w_load_mul    = (r_state == FIN) && w_slot_free && !w_mul_busy;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    // Extra MSB gives carry for ADD and borrow (a<b unsigned) for SUB.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[c_msb] == b[c_msb]) && (w_sum[c_msb] != a[c_msb]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NAND: w_res = ~(a & b);
            OP_XNOR: w_res = ~(a ^ b);
            OP_CMP: begin
                w_res[0] = (a == b);
                w_res[1] = (a > b);
                w_res[2] = (a < b);
            end
            OP_SHL:  w_res = a << b[SHW-1:0];
            OP_SHR:  w_res = a >> b[SHW-1:0];
            OP_MUL:  w_res = '0;   // handled by the iterative multiplier
            default: w_err = 1'b1; // reserved: all-zero result and flags
        endcase
    end

    always_comb begin
        w_flags        = '0;
        w_flags[F_Z]   = !w_err && (w_res == '0);
        w_flags[F_C]   = w_c;
        w_flags[F_V]   = w_v;
        w_flags[F_N]   = w_res[c_msb];
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    always_comb begin
        w_mul_flags      = '0;
        w_mul_flags[F_Z] = (w_prod == '0);
        w_mul_flags[F_C] = (w_prod[2*WIDTH-1:WIDTH] != '0);
        w_mul_flags[F_N] = w_prod[2*WIDTH-1];
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_nxt = MUL;
            MUL:     if (w_mul_done)  w_state_nxt = FIN;
            FIN:     if (w_load_mul)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: loads on a new result, otherwise holds; valid
    // drops only when the consumer takes the result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else if (w_load_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_result_hi <= '0;
            r_flags     <= w_flags;
            r_err       <= w_err;
        end else if (w_load_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_prod[WIDTH-1:0];
            r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_flags     <= w_mul_flags;
            r_err       <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe. Directed scenarios plus a
//               randomized phase; every cycle is compared against a
//               behavioural model (arithmetic on integers, result FIFO and
//               a cycle count for the multiply latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, err;
    logic [W-1:0] a, b, result, result_hi;
    logic [3:0]   opcode, flags;

    logic         d16_in_valid, d16_in_ready, d16_out_valid, d16_err;
    logic [15:0]  d16_a, d16_b, d16_result, d16_result_hi;
    logic [3:0]   d16_opcode, d16_flags;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .flags(flags), .err(err)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .a(d16_a), .b(d16_b), .opcode(d16_opcode), .out_valid(d16_out_valid),
        .out_ready(1'b1), .result(d16_result), .result_hi(d16_result_hi),
        .flags(d16_flags), .err(d16_err)
    );

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_known  = 1'b0;
    bit   m_ov     = 1'b0;
    int   m_phase  = 0;   // 0 idle, 1 multiplying, 2 product waiting for slot
    int   m_cnt    = 0;

    // Reference result of one operation from the arithmetic definition.
    function automatic exp_t model(int w, longint av, longint bv, int op);
        exp_t   e;
        longint mask, msbv, sa, sb, sv, r, p, hi;
        bit     c, v, z, n;
        mask = (longint'(1) << w) - 1;
        msbv = longint'(1) << (w - 1);
        sa = (av >= msbv) ? av - (mask + 1) : av;
        sb = (bv >= msbv) ? bv - (mask + 1) : bv;
        r = 0; p = 0; hi = 0; c = 0; v = 0; z = 0; n = 0; sv = 0;
        e.err = 1'b0;
        case (op)
            0: begin r = (av + bv) & mask; c = (av + bv) > mask; sv = sa + sb;
                     v = (sv > msbv - 1) || (sv < -msbv); end
            1: begin r = (av - bv) & mask; c = av < bv; sv = sa - sb;
                     v = (sv > msbv - 1) || (sv < -msbv); end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = (~(av & bv)) & mask;
            6: r = (~(av ^ bv)) & mask;
            7: r = ((av == bv) ? 1 : 0) + ((av > bv) ? 2 : 0) + ((av < bv) ? 4 : 0);
            8: r = (av << (bv % w)) & mask;
            9: r = av >> (bv % w);
            10: begin p = av * bv; r = p & mask; hi = p >> w; end
            default: e.err = 1'b1;
        endcase
        if (op == 10) begin
            z = (p == 0); c = (hi != 0); n = (hi >= msbv); v = 0;
        end else if (!e.err) begin
            z = (r == 0); n = (r >= msbv);
        end
        e.res   = 16'(r);
        e.hi    = 16'(hi);
        e.flags = {n, v, c, z};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model at the falling edge,
    // advance the model for the coming rising edge, return #1 after it.
    task automatic step();
        bit   ir, acc, load;
        exp_t e;
        @(negedge clk);
        ir = (m_phase == 0) && (!m_ov || out_ready);
        if (m_known) begin
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("in_ready", 32'(in_ready), 32'(ir));
            if (m_ov) begin
                n_checks++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL scoreboard: observed valid output, expected none pending");
                end
                if (q.size() > 0) begin
                    e = q[0];
                    check("result", 32'(result), 32'(e.res));
                    check("result_hi", 32'(result_hi), 32'(e.hi));
                    check("flags", 32'(flags), 32'(e.flags));
                    check("err", 32'(err), 32'(e.err));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
        if (!rst_n) begin
            q.delete();
            m_ov = 1'b0; m_phase = 0; m_cnt = 0; m_known = 1'b1;
        end else if (m_known) begin
            acc  = in_valid && ir;
            load = 1'b0;
            if (acc) begin
                q.push_back(model(W, longint'(a), longint'(b), int'(opcode)));
                if (opcode == 4'd10) begin m_phase = 1; m_cnt = W; end
                else load = 1'b1;
            end else if (m_phase == 1) begin
                m_cnt--;
                if (m_cnt == 0) m_phase = 2;
            end else if (m_phase == 2 && (!m_ov || out_ready)) begin
                load = 1'b1; m_phase = 0;
            end
            m_ov = load ? 1'b1 : (out_ready ? 1'b0 : m_ov);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = 1'b1; opcode = op; a = av; b = bv;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; opcode = '0;
        d16_in_valid = 1'b0; d16_a = '0; d16_b = '0; d16_opcode = '0;
        step(); step();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_result_hi", 32'(result_hi), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // ADD with carry and negative result, latency 1
        offer(4'd0, 8'd255, 8'd255); step();
        check("add_valid", 32'(out_valid), 1);
        check("add_result", 32'(result), 32'h0FE);
        check("add_flags", 32'(flags), 32'b1010);

        // SUB equal, then SUB with borrow, back-to-back
        offer(4'd1, 8'd10, 8'd10); step();
        check("sub_eq_result", 32'(result), 0);
        check("sub_eq_flags", 32'(flags), 32'b0001);
        offer(4'd1, 8'd5, 8'd25); step();
        check("sub_bor_result", 32'(result), 32'h0EC);
        check("sub_bor_flags", 32'(flags), 32'b1010);

        // MUL 255*255: nine cycles to valid; a later op is offered but held off
        offer(4'd10, 8'd255, 8'd255); step();
        offer(4'd0, 8'd7, 8'd8);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("mul_wait_valid", 32'(out_valid), 0);
            check("mul_wait_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0; step();
        check("mul_valid", 32'(out_valid), 1);
        check("mul_lo", 32'(result), 32'h01);
        check("mul_hi", 32'(result_hi), 32'hFE);
        check("mul_flags", 32'(flags), 32'b1010);
        step();

        // Back-pressure: second ADD waits until the first is consumed
        out_ready = 1'b0;
        offer(4'd0, 8'd1, 8'd1); step();
        offer(4'd0, 8'd2, 8'd2);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_result", 32'(result), 32'h02);
            check("bp_hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1; step();
        check("bp_next_result", 32'(result), 32'h04);
        check("bp_next_valid", 32'(out_valid), 1);
        in_valid = 1'b0; step();
        check("bp_drained", 32'(out_valid), 0);

        // Reset in the middle of a multiply
        offer(4'd10, 8'd25, 8'd5); step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0; step();
        check("rmul_valid", 32'(out_valid), 0);
        check("rmul_result", 32'(result), 0);
        check("rmul_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("rmul_no_stale", 32'(out_valid), 0);
        end

        // Reserved opcode, then CMP
        offer(4'hF, 8'd3, 8'd4); step();
        check("rsv_result", 32'(result), 0);
        check("rsv_hi", 32'(result_hi), 0);
        check("rsv_flags", 32'(flags), 0);
        check("rsv_err", 32'(err), 1);
        offer(4'd7, 8'd2, 8'd0); step();
        check("cmp_result", 32'(result), 32'h02);
        check("cmp_err", 32'(err), 0);
        in_valid = 1'b0; step();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = ($urandom_range(0, 7) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 15; k++) step();
        check("rand_drained", 32'(out_valid), 0);

        // WIDTH=16 instance: no carry out of bit 15
        d16_in_valid = 1'b1; d16_opcode = 4'd0; d16_a = 16'd255; d16_b = 16'd255;
        step();
        d16_in_valid = 1'b0;
        check("w16_valid", 32'(d16_out_valid), 1);
        check("w16_result", 32'(d16_result), 32'h01FE);
        check("w16_flags", 32'(d16_flags), 0);
        check("w16_err", 32'(d16_err), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
